// File: rtl/disp_defs.sv
// Shared definitions for the display driver: FSM encoding, segment constants,
// the active-low hex glyph table and the BCD adjust step.
package disp_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         CONV_BITS_DEF = 8;
    localparam int         BCD_DIGITS    = 3;
    localparam logic [6:0] BLANK_SEG     = 7'h7F;
    localparam logic [6:0] MINUS_SEG     = 7'h3F;

    // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Double-dabble correction applied before every shift.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [4*BCD_DIGITS-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit nibble to active-low seven-segment glyph decoder.
module seg7_decode
    import disp_defs::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_glyph(nibble);

endmodule

// File: rtl/disp_driver.sv
// Six-digit seven-segment driver: sequential BCD conversion of the data bus on HEX3..HEX0
// and hex display of ip on HEX5..HEX4. Optional macro: DISP_LEADING_ZERO_BLANK_EN.
module disp_driver
    import disp_defs::*;
#(
    parameter int         CONV_BITS = disp_defs::CONV_BITS_DEF,
    parameter logic [6:0] BLANK_SEG = disp_defs::BLANK_SEG,
    parameter logic [6:0] MINUS_SEG = disp_defs::MINUS_SEG
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 dval,
    input  logic [CONV_BITS-1:0] dout,
    input  logic                 mode,
    input  logic [7:0]           ip,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic [6:0]           hex3,
    output logic [6:0]           hex4,
    output logic [6:0]           hex5,
    output logic                 busy
);

    localparam int               CNT_W     = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
    localparam int               BCD_W     = 4 * BCD_DIGITS;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(CONV_BITS - 1);

    state_t               state;
    logic [CNT_W-1:0]     iter;
    logic [BCD_W-1:0]     bcd;
    logic [CONV_BITS-1:0] bin;
    logic                 sign;
    logic                 shadow_valid;
    logic [CONV_BITS:0]   shadow;
    logic                 pend_valid;
    logic [CONV_BITS:0]   pend;

    logic [CONV_BITS:0]   live;
    logic                 dval_trig;
    logic                 pend_trig;
    logic                 trigger;
    logic [CONV_BITS:0]   operand;
    logic                 neg;
    logic [CONV_BITS-1:0] magnitude;
    logic [BCD_W-1:0]     bcd_adj;

    logic [6:0]           units_seg;
    logic [6:0]           tens_seg;
    logic [6:0]           hund_seg;
    logic [6:0]           ip_lo_seg;
    logic [6:0]           ip_hi_seg;

    assign live = {mode, dout};

    // A pending value that differs from what is shown takes priority over the live bus.
    always_comb begin
        dval_trig = dval && (!shadow_valid || (live != shadow));
        pend_trig = pend_valid && (pend != shadow);
        trigger   = dval_trig || pend_trig;
        operand   = pend_trig ? pend : live;
        neg       = operand[CONV_BITS] && operand[CONV_BITS-1];
        magnitude = neg ? -operand[CONV_BITS-1:0] : operand[CONV_BITS-1:0];
        bcd_adj   = bcd_adjust(bcd);
    end

    seg7_decode u_units (.nibble(bcd[3:0]),  .seg(units_seg));
    seg7_decode u_tens  (.nibble(bcd[7:4]),  .seg(tens_seg));
    seg7_decode u_hund  (.nibble(bcd[11:8]), .seg(hund_seg));
    seg7_decode u_ip_lo (.nibble(ip[3:0]),   .seg(ip_lo_seg));
    seg7_decode u_ip_hi (.nibble(ip[7:4]),   .seg(ip_hi_seg));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            iter         <= '0;
            bcd          <= '0;
            bin          <= '0;
            sign         <= 1'b0;
            shadow_valid <= 1'b0;
            shadow       <= '0;
            pend_valid   <= 1'b0;
            pend         <= '0;
            busy         <= 1'b0;
            hex0         <= BLANK_SEG;
            hex1         <= BLANK_SEG;
            hex2         <= BLANK_SEG;
            hex3         <= BLANK_SEG;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        shadow       <= operand;
                        shadow_valid <= 1'b1;
                        pend_valid   <= 1'b0;
                        bcd          <= '0;
                        bin          <= magnitude;
                        sign         <= neg;
                        iter         <= '0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    if (dval) begin
                        pend       <= live;
                        pend_valid <= 1'b1;
                    end
                    if (iter == LAST_ITER) begin
                        iter  <= '0;
                        state <= DONE;
                    end else begin
                        iter <= iter + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (dval) begin
                        pend       <= live;
                        pend_valid <= 1'b1;
                    end
                    hex0 <= units_seg;
`ifdef DISP_LEADING_ZERO_BLANK_EN
                    hex1 <= ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) ? BLANK_SEG : tens_seg;
                    hex2 <= (bcd[11:8] == 4'd0) ? BLANK_SEG : hund_seg;
`else
                    hex1 <= tens_seg;
                    hex2 <= hund_seg;
`endif
                    hex3  <= sign ? MINUS_SEG : BLANK_SEG;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The ip digits track the bus every cycle, independent of the conversion FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hex4 <= hex_glyph(4'h0);
            hex5 <= hex_glyph(4'h0);
        end else begin
            hex4 <= ip_lo_seg;
            hex5 <= ip_hi_seg;
        end
    end

endmodule

// File: tb/tb_disp_driver.sv
// Self-checking bench for disp_driver: table-driven conversions with a scoreboard,
// plus hand-written sequences for pending, ip, mid-conversion reset and steady-input cases.
`timescale 1ns/1ps
module tb_disp_driver;

    logic       clk = 1'b0;
    logic       resetn;
    logic       dval;
    logic       mode;
    logic [7:0] dout;
    logic [7:0] ip;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       busy;

    disp_driver dut (
        .clk(clk), .resetn(resetn), .dval(dval), .dout(dout), .mode(mode), .ip(ip),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] d;
        logic       neg;
        int         hund;
        int         tens;
        int         units;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   conv_count = 0;
    bit   watch_42 = 1'b0;
    bit   seen_42 = 1'b0;

    always @(posedge busy) conv_count++;

    always @(posedge clk) begin
        if (watch_42 && hex1 === 7'h19 && hex0 === 7'h24) seen_42 = 1'b1;
    end

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mode = v.m;
        dout = v.d;
        dval = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t v;
        logic [6:0] e0, e1, e2, e3;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        v  = exp_q.pop_front();
        e3 = v.neg ? 7'h3F : 7'h7F;
        e2 = glyph(v.hund);
        e1 = glyph(v.tens);
        e0 = glyph(v.units);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if (v.hund == 0) e2 = 7'h7F;
        if (v.hund == 0 && v.tens == 0) e1 = 7'h7F;
`endif
        check({tag, ".hex3"}, 32'(hex3), 32'(e3));
        check({tag, ".hex2"}, 32'(hex2), 32'(e2));
        check({tag, ".hex1"}, 32'(hex1), 32'(e1));
        check({tag, ".hex0"}, 32'(hex0), 32'(e0));
    endtask

    // Returns after the edge where busy drops; counts busy samples seen before that.
    task automatic waitConversion(input string tag, output int cycles);
        bit done;
        cycles = 0;
        done   = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) cycles++;
            else if (cycles > 0) done = 1'b1;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".hex0"}, 32'(hex0), 32'h7F);
        check({tag, ".hex1"}, 32'(hex1), 32'h7F);
        check({tag, ".hex2"}, 32'(hex2), 32'h7F);
        check({tag, ".hex3"}, 32'(hex3), 32'h7F);
        check({tag, ".hex4"}, 32'(hex4), 32'h40);
        check({tag, ".hex5"}, 32'(hex5), 32'h40);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   cyc;
        int   c0;

        vecs[0] = '{1'b0, 8'hFF, 1'b0, 2, 5, 5};
        vecs[1] = '{1'b1, 8'h80, 1'b1, 1, 2, 8};
        vecs[2] = '{1'b1, 8'hF9, 1'b1, 0, 0, 7};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 0, 0, 0};
        vecs[4] = '{1'b0, 8'h0A, 1'b0, 0, 1, 0};
        vecs[5] = '{1'b1, 8'h7F, 1'b0, 1, 2, 7};
        vecs[6] = '{1'b1, 8'hFF, 1'b1, 0, 0, 1};
        vecs[7] = '{1'b0, 8'hC8, 1'b0, 2, 0, 0};
        vecs[8] = '{1'b1, 8'h9C, 1'b1, 1, 0, 0};
        vecs[9] = '{1'b0, 8'h63, 1'b0, 0, 9, 9};

        resetn = 1'b0;
        dval   = 1'b0;
        mode   = 1'b0;
        dout   = 8'h00;
        ip     = 8'h00;
        #22;
        checkReset("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            waitConversion($sformatf("vec%0d", i), cyc);
            check($sformatf("vec%0d.busy_cycles", i), 32'(cyc), 32'd9);
            checkOutput($sformatf("vec%0d", i));
        end

        // Updates while busy: only the latest value is converted afterwards.
        watch_42 = 1'b1;
        c0 = conv_count;
        v  = '{1'b0, 8'h05, 1'b0, 0, 0, 5};
        applyStimulus(v);
        @(posedge clk);
        #1;
        dout = 8'h2A;
        @(posedge clk);
        #1;
        dout = 8'h63;
        exp_q.push_back('{1'b0, 8'h63, 1'b0, 0, 9, 9});
        waitConversion("pend1", cyc);
        checkOutput("pend1");
        waitConversion("pend2", cyc);
        check("pend2.busy_cycles", 32'(cyc), 32'd9);
        checkOutput("pend2");
        repeat (15) @(posedge clk);
        #1;
        check("pend.conversions", 32'(conv_count - c0), 32'd2);
        check("pend.saw_42", 32'(seen_42), 32'd0);
        watch_42 = 1'b0;

        ip = 8'h00;
        @(posedge clk);
        #1;
        ip = 8'h3C;
        @(posedge clk);
        #1;
        check("ip3c.hex5", 32'(hex5), 32'h30);
        check("ip3c.hex4", 32'(hex4), 32'h46);

        // ip keeps updating while a conversion runs.
        v = '{1'b1, 8'hC8, 1'b1, 0, 5, 6};
        applyStimulus(v);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        ip = 8'hA5;
        check("ip_mid.hold_hex5", 32'(hex5), 32'h30);
        @(posedge clk);
        #1;
        check("ip_mid.busy", 32'(busy), 32'd1);
        check("ip_mid.hex5", 32'(hex5), 32'h08);
        check("ip_mid.hex4", 32'(hex4), 32'h12);
        waitConversion("ip_mid", cyc);
        checkOutput("ip_mid");

        // Reset during the fourth shift iteration.
        mode = 1'b0;
        dout = 8'h64;
        dval = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkReset("mid_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_q.push_back('{1'b0, 8'h64, 1'b0, 1, 0, 0});
        waitConversion("after_reset", cyc);
        check("after_reset.busy_cycles", 32'(cyc), 32'd9);
        checkOutput("after_reset");

        // Steady input converts once; a mode flip converts again.
        c0 = conv_count;
        v  = '{1'b0, 8'h10, 1'b0, 0, 1, 6};
        applyStimulus(v);
        waitConversion("steady", cyc);
        checkOutput("steady");
        repeat (40) @(posedge clk);
        #1;
        check("steady.conversions", 32'(conv_count - c0), 32'd1);
        check("steady.busy", 32'(busy), 32'd0);
        v = '{1'b1, 8'h10, 1'b0, 0, 1, 6};
        applyStimulus(v);
        waitConversion("mode_flip", cyc);
        check("mode_flip.busy_cycles", 32'(cyc), 32'd9);
        checkOutput("mode_flip");
        repeat (20) @(posedge clk);
        #1;
        check("mode_flip.conversions", 32'(conv_count - c0), 32'd2);

        // With dval low the display holds whatever dout does.
        dval = 1'b0;
        dout = 8'h77;
        mode = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("hold.conversions", 32'(conv_count - c0), 32'd2);
        exp_q.push_back('{1'b1, 8'h10, 1'b0, 0, 1, 6});
        checkOutput("hold");

        check("scoreboard.leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/disp_driver.md
Name: disp_driver

Overview:
- Downstream stage of the soc top level on the DE board. Consumes the CPU data bus (dout/dval), the instruction pointer and the display mode bit, and drives six active-low seven-segment displays.
- dout is converted to decimal by a sequential shift-add-3 (double-dabble) engine and shown on HEX3..HEX0, either unsigned or signed depending on mode.
- ip is shown in hex on HEX5..HEX4.

Parameters:
- CONV_BITS, 8, width of the data operand fed to the BCD engine; fixes SHIFT iteration count.
- BLANK_SEG, 7'h7F, active-low pattern for a dark digit.
- MINUS_SEG, 7'h3F, active-low pattern for the minus sign (segment g only).

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous, active-low reset
- dval  in  1  data valid level from soc; dout sampled only while high
- dout  in  8  data bus value to display
- mode  in  1  0 = unsigned decimal (0..255), 1 = signed two's complement (-128..127)
- ip  in  8  instruction pointer, displayed in hex
- hex0  out  7  units digit, active-low, bit0 = a .. bit6 = g
- hex1  out  7  tens digit
- hex2  out  7  hundreds digit
- hex3  out  7  sign digit (MINUS_SEG or BLANK_SEG)
- hex4  out  7  ip[3:0] hex digit
- hex5  out  7  ip[7:4] hex digit
- busy  out  1  high while a conversion is in flight

Behaviour:
- Reset (asynchronous, resetn low) sets:
  - hex0..hex3 = BLANK_SEG; hex4 = hex5 = glyph '0' (7'h40); busy = 0.
  - State = IDLE; shadow register invalid; pending flag clear.
- ip path: hex4/hex5 are registered hex decodes of ip, 1-cycle latency, updated every cycle regardless of FSM state.
- Trigger, evaluated in IDLE only. It fires when either:
  - dval = 1 and ({mode,dout} != shadow, or shadow invalid), or
  - the pending flag is set and pending value != shadow.
- FSM states and transitions:
  - IDLE: on trigger at edge k, capture operand, set shadow = {mode,value}, clear pending, go to SHIFT. Operand = dout, or the pending value if pending is set.
    - If mode = 1 and operand[7] = 1: magnitude = two's-complement negate (0x80 gives 128) and the sign flag is set.
  - SHIFT: CONV_BITS iterations, edges k+1..k+8. Before each shift, add 3 to any BCD nibble >= 5. Counter wraps to 0 on exit. Go to DONE.
  - DONE: at edge k+9, register hex0..hex3 from the BCD result and sign flag. Return to IDLE.
  - Display latency: value visible after edge k+9.
- busy = 1 in SHIFT and DONE, 0 otherwise.
- hex0..hex3 hold their old value throughout a conversion; there is no partial update.
- dval = 1 during busy: latch {mode,dout} into the pending register. Latest value wins; the pending flag is set.
- dval low: displays hold their last value. No clearing.
- mode toggle while dval = 1 triggers re-conversion of the same dout.
- Reset mid-conversion: abort immediately to reset values; the pending value is discarded.

Optional Feature:
- Macro: DISP_LEADING_ZERO_BLANK_EN.
- Defined:
  - hex2 = BLANK_SEG when hundreds = 0.
  - hex1 = BLANK_SEG when hundreds = 0 and tens = 0.
  - hex0 is always shown.
  - The minus sign stays on hex3.
- Undefined: all three digits are always shown (e.g. "007").

Decomposition:
- Shared include/package disp_defs holds:
  - State encodings IDLE/SHIFT/DONE.
  - BLANK_SEG and MINUS_SEG.
  - The hex glyph table 0-F.
- One natural sub-module: seg7_decode (4-bit nibble to active-low 7-segment glyph). It is instantiated 5 times: hex0-hex2, hex4, hex5.

Test Plan:
- Reset, then dval = 1, mode = 0, dout = 0xFF: busy high for 9 cycles; after edge k+9, hex2/1/0 = '2','5','5' and hex3 = blank.
- mode = 1, dout = 0x80: hex3 = minus and digits "128". With the macro, same value. Then dout = 0xF9 gives "-7": with the macro hex2/hex1 blank; without it, "007".
- dval = 1, dout = 0x05, then dout = 0x2A and 0x63 on consecutive cycles while busy: the display ends at "099" with exactly two conversions, and 0x2A never appears.
- ip stepping 0x00 to 0x3C: hex5/hex4 = '3','C' one cycle after ip changes, including mid-conversion.
- Assert resetn low at SHIFT iteration 4 with dout = 0x64: all outputs return to reset values asynchronously. After release, with dval still 1, a fresh conversion shows "100".
- dval = 1 with dout steady at 0x10 for 50 cycles: exactly one conversion (busy pulses once). Toggling mode with dout unchanged triggers one further conversion.
